cpu_mc: RTL and testbench

CPU_MC -- requirements
Module: cpu_mc

---
 rtl/cpu_mc_if.sv | 28 ++
 rtl/cpu_mc.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_mc.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mc_if.sv
// Instruction and data memory request/acknowledge bus for cpu_mc.
// The core is the master; the memories (or a bench) sit on the slave side.
interface cpu_mc_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu_mc.sv
// Multi-cycle 16-bit core: FETCH/DECODE/EXEC/(MEM)/WB with saturating ALU, branches,
// request timeouts on both memory ports and sticky halt/error/illegal status.
module cpu_mc #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_mc_if.master         bus,
  output logic             hlt,
  output logic [15:0]      pc,
  output logic             err,
  output logic             ill,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt, StErr} state_e;

  state_e           state_q;
  logic [15:0]      pc_q, instr_q, a_q, b_q, d_q, res_q, npc_q, tmo_q;
  logic [15:0]      rf_q [16];
  logic             z_q, n_q, v_q;
  logic             z_p_q, n_p_q, v_p_q, zwe_q, nvwe_q, rwe_q, ill_p_q, hlt_p_q;
  logic             hlt_q, err_q, ill_q;
  logic [CNT_W-1:0] ret_q;
  logic             imem_req_q, dmem_req_q, dmem_we_q;
  logic [15:0]      dmem_addr_q, dmem_wdata_q;

  logic [3:0]  op, rd, rs, rt;
  logic [16:0] wide;
  logic [15:0] ex_res, ex_npc, mem_addr;
  logic        ex_rwe, ex_z, ex_n, ex_v, ex_zwe, ex_nvwe, ex_mem, ex_ill, ex_hlt, cond_ok;

  assign op = instr_q[15:12];
  assign rd = instr_q[11:8];
  assign rs = instr_q[7:4];
  assign rt = instr_q[3:0];

  always_comb begin
    unique case (instr_q[11:9])
      3'b000:  cond_ok = !z_q;
      3'b001:  cond_ok = z_q;
      3'b010:  cond_ok = !z_q && !n_q;
      3'b011:  cond_ok = n_q;
      3'b100:  cond_ok = z_q || (!z_q && !n_q);
      3'b101:  cond_ok = n_q || z_q;
      3'b110:  cond_ok = v_q;
      default: cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    wide     = '0;
    ex_res   = '0;
    ex_rwe   = 1'b0;
    ex_n     = 1'b0;
    ex_v     = 1'b0;
    ex_zwe   = 1'b0;
    ex_nvwe  = 1'b0;
    ex_mem   = 1'b0;
    ex_ill   = 1'b0;
    ex_hlt   = 1'b0;
    ex_npc   = pc_q + 16'd2;
    mem_addr = (a_q & 16'hFFFE) + {{11{rt[3]}}, rt, 1'b0};
    case (op)
      4'h0, 4'h1: begin
        // 17-bit signed result: bits 16 and 15 disagree exactly on overflow
        wide    = (op == 4'h0) ? ({a_q[15], a_q} + {b_q[15], b_q})
                               : ({a_q[15], a_q} - {b_q[15], b_q});
        ex_v    = wide[16] ^ wide[15];
        ex_res  = ex_v ? (wide[16] ? 16'h8000 : 16'h7FFF) : wide[15:0];
        ex_n    = ex_res[15];
        ex_rwe  = 1'b1;
        ex_zwe  = 1'b1;
        ex_nvwe = 1'b1;
      end
      4'h2: begin ex_res = a_q ^ b_q;             ex_rwe = 1'b1; ex_zwe = 1'b1; end
      4'h4: begin ex_res = a_q << rt;             ex_rwe = 1'b1; ex_zwe = 1'b1; end
      4'h5: begin ex_res = $signed(a_q) >>> rt;   ex_rwe = 1'b1; ex_zwe = 1'b1; end
      4'h6: begin ex_res = 16'({a_q, a_q} >> rt); ex_rwe = 1'b1; ex_zwe = 1'b1; end
      4'h3, 4'h7: ex_ill = 1'b1;
      4'h8: begin ex_mem = 1'b1; ex_rwe = 1'b1; end
      4'h9: ex_mem = 1'b1;
      4'hA: begin ex_res = {d_q[15:8], instr_q[7:0]}; ex_rwe = 1'b1; end
      4'hB: begin ex_res = {instr_q[7:0], d_q[7:0]};  ex_rwe = 1'b1; end
      4'hC: if (cond_ok) ex_npc = pc_q + 16'd2 + {{6{instr_q[8]}}, instr_q[8:0], 1'b0};
      4'hD: if (cond_ok) ex_npc = a_q;
      4'hE: begin ex_res = pc_q + 16'd2; ex_rwe = 1'b1; end
      default: begin ex_hlt = 1'b1; ex_npc = pc_q; end
    endcase
    ex_z = (ex_res == 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      d_q          <= '0;
      res_q        <= '0;
      npc_q        <= '0;
      tmo_q        <= '0;
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      {z_q, n_q, v_q}                   <= '0;
      {z_p_q, n_p_q, v_p_q}             <= '0;
      {zwe_q, nvwe_q, rwe_q}            <= '0;
      {ill_p_q, hlt_p_q}                <= '0;
      {hlt_q, err_q, ill_q}             <= '0;
      ret_q        <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
    end else begin
      case (state_q)
        StFetch: begin
          // First cycle after reset raises the request; acks before that are ignored
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
            tmo_q      <= '0;
          end else if (bus.imem_ack) begin
            instr_q    <= bus.imem_rdata;
            imem_req_q <= 1'b0;
            state_q    <= StDecode;
          end else if (tmo_q == 16'(TIMEOUT - 1)) begin
            imem_req_q <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= StErr;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        StDecode: begin
          a_q     <= rf_q[rs];
          b_q     <= rf_q[rt];
          d_q     <= rf_q[rd];
          state_q <= StExec;
        end
        StExec: begin
          res_q   <= ex_res;
          rwe_q   <= ex_rwe;
          z_p_q   <= ex_z;
          n_p_q   <= ex_n;
          v_p_q   <= ex_v;
          zwe_q   <= ex_zwe;
          nvwe_q  <= ex_nvwe;
          ill_p_q <= ex_ill;
          hlt_p_q <= ex_hlt;
          npc_q   <= ex_npc;
          if (ex_mem) begin
            dmem_req_q   <= 1'b1;
            dmem_we_q    <= op[0];
            dmem_addr_q  <= mem_addr;
            dmem_wdata_q <= d_q;
            tmo_q        <= '0;
            state_q      <= StMem;
          end else begin
            state_q <= StWb;
          end
        end
        StMem: begin
          if (bus.dmem_ack) begin
            dmem_req_q <= 1'b0;
            if (!dmem_we_q) res_q <= bus.dmem_rdata;
            state_q <= StWb;
          end else if (tmo_q == 16'(TIMEOUT - 1)) begin
            dmem_req_q <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= StErr;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        StWb: begin
          if (rwe_q && (rd != 4'd0)) rf_q[rd] <= res_q;
          if (zwe_q) z_q <= z_p_q;
          if (nvwe_q) begin
            n_q <= n_p_q;
            v_q <= v_p_q;
          end
          if (ill_p_q) ill_q <= 1'b1;
          pc_q  <= npc_q;
          ret_q <= ret_q + CNT_W'(1);
          if (hlt_p_q) begin
            hlt_q   <= 1'b1;
            state_q <= StHalt;
          end else begin
            imem_req_q <= 1'b1;
            tmo_q      <= '0;
            state_q    <= StFetch;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign hlt            = hlt_q;
  assign pc             = pc_q;
  assign err            = err_q;
  assign ill            = ill_q;
  assign retired        = ret_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed bench for cpu_mc: table of ALU vectors run as tiny programs, plus
// hand-written sequences for branches, memory waits, timeout, halt and reset.
module tb_cpu_mc;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        hlt, err, ill;
  logic [15:0] pc;
  logic [15:0] retired;

  cpu_mc_if bus ();

  cpu_mc #(.RESET_PC(16'h0000), .TIMEOUT(16), .CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .hlt     (hlt),
    .pc      (pc),
    .err     (err),
    .ill     (ill),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  int idelay = 0, ddelay = 0, never_addr = -1;
  int iwait = 0, dwait = 0;
  bit iack_prev = 0, dack_prev = 0;
  logic [15:0] flog [$];
  int fcyc [$];
  int fbase = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Instruction memory: ack after idelay waiting cycles, never for never_addr
  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.imem_ack = 1'b0;
        iwait = 0;
        iack_prev = 0;
      end else begin
        if (iack_prev) chk("imem_req_drop_after_ack", {31'd0, bus.imem_req}, 0);
        iack_prev = 0;
        bus.imem_ack = 1'b0;
        if (bus.imem_req) begin
          if (int'(bus.imem_addr) != never_addr && iwait >= idelay) begin
            bus.imem_ack = 1'b1;
            bus.imem_rdata = imem[bus.imem_addr[8:1]];
            flog.push_back(bus.imem_addr);
            fcyc.push_back(cyc);
            iwait = 0;
            iack_prev = 1;
          end else iwait++;
        end else iwait = 0;
      end
    end
  end

  // Data memory: cleared while reset is held, ack after ddelay waiting cycles
  initial begin
    bus.dmem_ack = 1'b0;
    bus.dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.dmem_ack = 1'b0;
        dwait = 0;
        dack_prev = 0;
        for (int k = 0; k < 256; k++) dmem[k] = 16'h0000;
      end else begin
        if (dack_prev) chk("dmem_req_drop_after_ack", {31'd0, bus.dmem_req}, 0);
        dack_prev = 0;
        bus.dmem_ack = 1'b0;
        if (bus.dmem_req) begin
          if (dwait >= ddelay) begin
            bus.dmem_ack = 1'b1;
            if (bus.dmem_we) dmem[bus.dmem_addr[8:1]] = bus.dmem_wdata;
            else bus.dmem_rdata = dmem[bus.dmem_addr[8:1]];
            dwait = 0;
            dack_prev = 1;
          end else dwait++;
        end else dwait = 0;
      end
    end
  end

  task automatic put(input logic [15:0] a, input logic [15:0] w);
    imem[a[8:1]] = w;
  endtask

  task automatic clear_imem();
    for (int k = 0; k < 256; k++) imem[k] = 16'hF000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    fbase = flog.size();
    rst_n = 1'b1;
  endtask

  task automatic run_until_hlt(input int max_cyc, input string name);
    int n;
    n = 0;
    while (!hlt && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!hlt) chk(name, 0, 1);
  endtask

  function automatic logic [15:0] fa(input int k);
    if (fbase + k < flog.size()) return flog[fbase + k];
    return 16'hDEAD;
  endfunction

  function automatic int fc(input int k);
    if (fbase + k < fcyc.size()) return fcyc[fbase + k];
    return -1000;
  endfunction

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic [15:0] res;
    logic        z;
    logic        n;
    logic        v;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int nrt;
    int cnt;
    logic [15:0] instr;

    vecs[0]  = '{4'h0, 16'h7FFF, 16'h7FFF, 4'h0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{4'h0, 16'h7FFF, 16'h0001, 4'h0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{4'h0, 16'h0003, 16'hFFFD, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'h0, 16'h8000, 16'h8000, 4'h0, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[4]  = '{4'h1, 16'h8000, 16'h0001, 4'h0, 16'h8000, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{4'h1, 16'h0005, 16'h0009, 4'h0, 16'hFFFC, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'h1, 16'h1234, 16'h1234, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'h2, 16'h1234, 16'h1234, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'h2, 16'hF0F0, 16'h0FF0, 4'h0, 16'hFF00, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'h4, 16'h8001, 16'h0000, 4'h1, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'h5, 16'h8000, 16'h0000, 4'h4, 16'hF800, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'h6, 16'h1234, 16'h0000, 4'h4, 16'h4123, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'h6, 16'h1234, 16'h0000, 4'h0, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'h4, 16'h8000, 16'h0000, 4'h1, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'h5, 16'h8000, 16'h0000, 4'hF, 16'hFFFF, 1'b0, 1'b0, 1'b0};

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hlt", {31'd0, hlt}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_ill", {31'd0, ill}, 0);
    chk("rst_retired", {16'd0, retired}, 0);
    chk("rst_pc", {16'd0, pc}, 32'h0000);
    chk("rst_imem_req", {31'd0, bus.imem_req}, 0);
    chk("rst_dmem_req", {31'd0, bus.dmem_req}, 0);

    // ALU vectors: result and flags observed through stores and conditional skips
    for (int i = 0; i < 15; i++) begin
      clear_imem();
      put(16'h00, {4'hA, 4'd1, vecs[i].a[7:0]});
      put(16'h02, {4'hB, 4'd1, vecs[i].a[15:8]});
      put(16'h04, {4'hA, 4'd2, vecs[i].b[7:0]});
      put(16'h06, {4'hB, 4'd2, vecs[i].b[15:8]});
      if (vecs[i].op[2]) instr = {vecs[i].op, 4'd3, 4'd1, vecs[i].sh};
      else instr = {vecs[i].op, 4'd3, 4'd1, 4'd2};
      put(16'h08, instr);
      put(16'h0A, 16'h9300);
      put(16'h0C, {4'hC, 3'b000, 9'd1});
      put(16'h0E, 16'hA501);
      put(16'h10, {4'hC, 3'b100, 9'd1});
      put(16'h12, 16'hA601);
      put(16'h14, {4'hC, 3'b110, 9'd1});
      put(16'h16, 16'hA701);
      put(16'h18, 16'h9501);
      put(16'h1A, 16'h9602);
      put(16'h1C, 16'h9703);
      put(16'h1E, 16'hF000);
      do_reset();
      run_until_hlt(600, $sformatf("v%0d_hlt_timeout", i));
      nrt = 16 - (vecs[i].z ? 0 : 1) - (vecs[i].n ? 0 : 1) - (vecs[i].v ? 1 : 0);
      chk($sformatf("v%0d_res", i), {16'd0, dmem[0]}, {16'd0, vecs[i].res});
      chk($sformatf("v%0d_z", i), {16'd0, dmem[1]}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_n", i), {16'd0, dmem[2]}, {31'd0, vecs[i].n});
      chk($sformatf("v%0d_not_v", i), {16'd0, dmem[3]}, {31'd0, !vecs[i].v});
      chk($sformatf("v%0d_retired", i), {16'd0, retired}, nrt);
      chk($sformatf("v%0d_pc", i), {16'd0, pc}, 32'h001E);
      chk($sformatf("v%0d_ill", i), {31'd0, ill}, 0);
      if (i == 0) begin
        chk("lat_alu", fc(2) - fc(1), 4);
        chk("lat_sw", fc(6) - fc(5), 5);
      end
    end

    // Taken and not-taken branches after SUB R3,R0,R0
    clear_imem();
    put(16'h00, 16'h1300);
    for (int k = 1; k < 8; k++) put(16'(2 * k), 16'hA800);
    put(16'h10, {4'hC, 3'b001, 9'd4});
    put(16'h12, 16'hF000);
    put(16'h1A, {4'hC, 3'b000, 9'd4});
    put(16'h1C, 16'hF000);
    do_reset();
    run_until_hlt(200, "br_hlt_timeout");
    chk("br_fetch_0x10", {16'd0, fa(8)}, 32'h0010);
    chk("br_taken_target", {16'd0, fa(9)}, 32'h001A);
    chk("br_not_taken", {16'd0, fa(10)}, 32'h001C);
    chk("br_retired", {16'd0, retired}, 11);

    // Store then load with 3 wait cycles on the data port
    ddelay = 3;
    clear_imem();
    put(16'h00, 16'hA1EF);
    put(16'h02, 16'hB1BE);
    put(16'h04, 16'hA920);
    put(16'h06, 16'h9190);
    put(16'h08, 16'h8490);
    put(16'h0A, 16'h9491);
    put(16'h0C, 16'hF000);
    do_reset();
    run_until_hlt(200, "mem_hlt_timeout");
    chk("mem_sw_0x20", {16'd0, dmem[8'h10]}, 32'hBEEF);
    chk("mem_lw_copy_0x22", {16'd0, dmem[8'h11]}, 32'hBEEF);
    chk("mem_sw_wait_latency", fc(4) - fc(3), 8);
    chk("mem_retired", {16'd0, retired}, 7);
    ddelay = 0;

    // Reserved opcode and PCS
    clear_imem();
    put(16'h00, 16'hA155);
    put(16'h02, 16'h3111);
    put(16'h04, 16'h9100);
    put(16'h06, {4'hC, 3'b111, 9'd20});
    put(16'h30, 16'hE500);
    put(16'h32, 16'h9501);
    put(16'h34, 16'hF000);
    do_reset();
    run_until_hlt(200, "red_hlt_timeout");
    chk("red_ill", {31'd0, ill}, 1);
    chk("red_r1_unchanged", {16'd0, dmem[0]}, 32'h0055);
    chk("red_pc_plus2", {16'd0, fa(2)}, 32'h0004);
    chk("pcs_r5", {16'd0, dmem[1]}, 32'h0032);
    chk("red_retired", {16'd0, retired}, 7);

    // Fetch timeout on the second instruction
    clear_imem();
    put(16'h00, 16'hA101);
    never_addr = 2;
    do_reset();
    cnt = 0;
    for (int k = 0; k < 100 && !err; k++) begin
      @(negedge clk);
      if (bus.imem_req && bus.imem_addr == 16'h0002) cnt++;
    end
    chk("tmo_err", {31'd0, err}, 1);
    chk("tmo_req_cycles", cnt, 16);
    chk("tmo_req_dropped", {31'd0, bus.imem_req}, 0);
    chk("tmo_retired", {16'd0, retired}, 1);
    chk("tmo_pc", {16'd0, pc}, 32'h0002);
    never_addr = -1;

    // Reset in the middle of a data access
    ddelay = 20;
    clear_imem();
    put(16'h00, 16'h8100);
    do_reset();
    for (int k = 0; k < 50 && !bus.dmem_req; k++) @(negedge clk);
    chk("mid_dmem_req_seen", {31'd0, bus.dmem_req}, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dmem_req", {31'd0, bus.dmem_req}, 0);
    chk("mid_rst_pc", {16'd0, pc}, 32'h0000);
    repeat (2) @(negedge clk);
    ddelay = 0;
    fbase = flog.size();
    rst_n = 1'b1;
    for (int k = 0; k < 20 && flog.size() <= fbase; k++) @(negedge clk);
    chk("mid_first_fetch", {16'd0, fa(0)}, 32'h0000);

    // HLT at 0x0004, then reset
    clear_imem();
    put(16'h00, 16'hA101);
    put(16'h02, 16'hA202);
    put(16'h04, 16'hF000);
    do_reset();
    run_until_hlt(100, "hlt_timeout");
    chk("hlt_flag", {31'd0, hlt}, 1);
    chk("hlt_pc", {16'd0, pc}, 32'h0004);
    chk("hlt_retired", {16'd0, retired}, 3);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.imem_req) cnt++;
    end
    chk("hlt_no_fetch", cnt, 0);
    rst_n = 1'b0;
    #1;
    chk("hlt_rst_clear", {31'd0, hlt}, 0);
    chk("hlt_rst_pc", {16'd0, pc}, 32'h0000);
    chk("hlt_rst_retired", {16'd0, retired}, 0);
    repeat (2) @(negedge clk);
    fbase = flog.size();
    rst_n = 1'b1;
    for (int k = 0; k < 20 && flog.size() <= fbase; k++) @(negedge clk);
    chk("hlt_refetch_reset_pc", {16'd0, fa(0)}, 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
